nes_controller_io: RTL and testbench



---
 rtl/nes_controller_io.sv | 109 ++++++++++
 tb/tb_nes_controller_io.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_io.sv
// Two-port NES joypad interface at $4016/$4017 that emulates a pair of 4021 shift registers.
// Defining CONTROLLER_SYNC_EN adds 2-flop synchronizers on the button inputs ahead of the reload path.
module nes_controller_io #(
  parameter logic [7:0] OPEN_BUS = 8'h40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pad0_buttons,
  input  logic [7:0] pad1_buttons
);

  logic       r_strobe;
  logic [1:0] r_acc_q;
  logic [7:0] r_sr0;
  logic [7:0] r_sr1;

  logic       w_acc;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_shift0;
  logic       w_shift1;
  logic       w_strobe_wr;
  logic [7:0] w_pad0;
  logic [7:0] w_pad1;
  logic       w_unused_din;

  assign w_acc       = ~cs_n & rd;
  assign w_acc0      = w_acc & ~addr;
  assign w_acc1      = w_acc & addr;
  assign w_strobe_wr = ~cs_n & wr & ~addr;
  assign w_unused_din = &{1'b0, din[7:1]};

  // A shift fires on the edge that first sees a pad's access gone.
  assign w_shift0 = r_acc_q[0] & ~w_acc0;
  assign w_shift1 = r_acc_q[1] & ~w_acc1;

`ifdef CONTROLLER_SYNC_EN
  logic [7:0] r_pad0_meta;
  logic [7:0] r_pad0_sync;
  logic [7:0] r_pad1_meta;
  logic [7:0] r_pad1_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pad0_meta <= 8'h00;
      r_pad0_sync <= 8'h00;
      r_pad1_meta <= 8'h00;
      r_pad1_sync <= 8'h00;
    end else begin
      r_pad0_meta <= pad0_buttons;
      r_pad0_sync <= r_pad0_meta;
      r_pad1_meta <= pad1_buttons;
      r_pad1_sync <= r_pad1_meta;
    end
  end

  assign w_pad0 = r_pad0_sync;
  assign w_pad1 = r_pad1_sync;
`else
  assign w_pad0 = pad0_buttons;
  assign w_pad1 = pad1_buttons;
`endif

  // NOTE: all state uses non-blocking assignments so every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe <= 1'b0;
      r_acc_q  <= 2'b00;
    end else begin
      if (w_strobe_wr) begin
        r_strobe <= din[0];
      end
      r_acc_q <= {w_acc1, w_acc0};
    end
  end

  // Strobe high reloads continuously and also blocks any shift in that same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr0 <= 8'h00;
      r_sr1 <= 8'h00;
    end else if (r_strobe) begin
      r_sr0 <= w_pad0;
      r_sr1 <= w_pad1;
    end else begin
      if (w_shift0) begin
        r_sr0 <= {1'b1, r_sr0[7:1]};
      end
      if (w_shift1) begin
        r_sr1 <= {1'b1, r_sr1[7:1]};
      end
    end
  end

  // NOTE: defaulting dout before the if keeps this combinational block from inferring a latch.
  always_comb begin
    dout = 8'h00;
    if (w_acc) begin
      dout = {OPEN_BUS[7:1], (addr ? r_sr1[0] : r_sr0[0])};
    end
  end

endmodule

// File: tb/tb_nes_controller_io.sv
// Self-checking bench for nes_controller_io: directed scenarios followed by random traffic, all checked
// against a latched-value-plus-read-count model of each pad.
module tb_nes_controller_io;

  localparam logic [7:0] OPEN_BUS = 8'h40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       addr = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] pad0_buttons = 8'h00;
  logic [7:0] pad1_buttons = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  // Model: strobe level, value captured when strobe last fell, and completed reads since then.
  bit         m_strobe = 1'b0;
  logic [7:0] m_lat [2];
  int         m_cnt [2];

  nes_controller_io #(.OPEN_BUS(OPEN_BUS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs_n         (cs_n),
    .addr         (addr),
    .rd           (rd),
    .wr           (wr),
    .din          (din),
    .dout         (dout),
    .pad0_buttons (pad0_buttons),
    .pad1_buttons (pad1_buttons)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int p);
    logic [7:0] v;
    if (m_strobe) begin
      v = (p == 1) ? pad1_buttons : pad0_buttons;
      return v[0];
    end
    if (m_cnt[p] < 8) begin
      v = m_lat[p];
      return v[m_cnt[p]];
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_strobe = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_lat[p] = 8'h00;
      m_cnt[p] = 0;
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic idle(input int n);
    cs_n = 1'b1; rd = 1'b0; wr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic a, input logic v);
    cs_n = 1'b0; wr = 1'b1; addr = a; din = {7'h55, v};
    @(negedge clk);
    cs_n = 1'b1; wr = 1'b0; din = 8'h00;
    if (a == 1'b0) begin
      if (m_strobe && !v) begin
        m_lat[0] = pad0_buttons;
        m_lat[1] = pad1_buttons;
      end
      if (m_strobe || v) begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end
      m_strobe = v;
    end
  endtask

  // Pads are held stable for several cycles around the strobe so the synchronized build agrees too.
  task automatic strobe_pulse(input logic [7:0] p0, input logic [7:0] p1);
    pad0_buttons = p0;
    pad1_buttons = p1;
    idle(3);
    write_reg(1'b0, 1'b1);
    idle(3);
    write_reg(1'b0, 1'b0);
  endtask

  task automatic read_pad(input string tag, input int p, input int len, input bit with_wr);
    logic e;
    e = exp_bit(p);
    cs_n = 1'b0; rd = 1'b1; addr = p[0];
    if (with_wr) begin
      wr = 1'b1; din = 8'h00;
    end
    for (int c = 0; c < len; c++) begin
      #1;
      check(tag, dout, {OPEN_BUS[7:1], e});
      @(negedge clk);
    end
    cs_n = 1'b1; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    if (!m_strobe && m_cnt[p] < 8) m_cnt[p]++;
  endtask

  initial begin
    logic [7:0] r0, r1;
    string tag;

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_dout", dout, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    // Never strobed: eight zeros then ones.
    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("nostrobe_rd%0d", i);
      read_pad(tag, 0, 1, 1'b0);
    end

    // A write to $4017 must not touch the strobe.
    write_reg(1'b1, 1'b1);
    read_pad("wr4017_ignored", 0, 1, 1'b0);

    // Known pattern through pad 0, reading past the end.
    strobe_pulse(8'b1000_1001, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("pattern_rd%0d", i);
      read_pad(tag, 0, 1, 1'b0);
    end

    // Strobe held high: reads follow the live A button and never shift.
    pad0_buttons = 8'h00;
    idle(3);
    write_reg(1'b0, 1'b1);
    idle(3);
    read_pad("strobe_hi_a0", 0, 1, 1'b0);
    pad0_buttons = 8'h01;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      tag = $sformatf("strobe_hi_a1_rd%0d", i);
      read_pad(tag, 0, 1, 1'b0);
    end
    write_reg(1'b0, 1'b0);

    // Pad 1 reads leave pad 0 untouched.
    strobe_pulse(8'h01, 8'h02);
    read_pad("pad1_rd0", 1, 1, 1'b0);
    read_pad("pad1_rd1", 1, 1, 1'b0);
    read_pad("pad0_after_pad1", 0, 1, 1'b0);

    // Long access counts once; a combined read+write still shifts.
    strobe_pulse(8'b0000_0110, 8'h00);
    read_pad("held_5cyc", 0, 5, 1'b0);
    read_pad("after_held", 0, 1, 1'b0);
    read_pad("rd_with_wr", 0, 2, 1'b1);
    read_pad("after_rd_wr", 0, 1, 1'b0);

    // Reset in mid-sequence clears everything.
    strobe_pulse(8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) read_pad("pre_reset", 0, 1, 1'b0);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("post_reset_rd%0d", i);
      read_pad(tag, 0, 1, 1'b0);
    end
    #1;
    check("idle_dout", dout, 8'h00);
    @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          r0 = 8'($urandom);
          r1 = 8'($urandom);
          strobe_pulse(r0, r1);
        end
        1: begin
          idle(1);
          #1;
          check("rand_idle", dout, 8'h00);
          @(negedge clk);
        end
        default: begin
          tag = $sformatf("rand_rd%0d", i);
          read_pad(tag, int'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1'b0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
